secded_ecc_fifo: RTL and testbench
==================================

SECDED_ECC_FIFO -- requirements
Module: secded_ecc_fifo

Interface
REQ-001 Parameter DW, default 10: data word width in bits, 1..64.
REQ-002 Parameter DEPTH, default 8: FIFO entries, power of two, 2..256.
REQ-003 Parameter CNT_W, default 8: error-counter width.
REQ-004 Derived constant PW: smallest p with 2^p >= DW+p+1. CW = DW+PW+1 is the stored codeword width. For DW=10: PW=4, CW=15.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 i_fifo_wreq  in  1  write request.
REQ-008 i_fifo_rreq  in  1  read request.
REQ-009 i_data  in  DW  write data.
REQ-010 i_inj_mask  in  CW  error-injection mask, XORed into the codeword on an accepted write.
REQ-011 i_cnt_clr  in  1  synchronous clear of both error counters.
REQ-012 o_fifo_empty  out  1  no entries stored.
REQ-013 o_fifo_full  out  1  DEPTH entries stored.
REQ-014 o_level  out  $clog2(DEPTH)+1  current entry count.
REQ-015 o_data  out  DW  corrected read data.
REQ-016 o_valid  out  1  o_data/error flags valid this cycle.
REQ-017 o_sec_err  out  1  single-bit error corrected on this read.
REQ-018 o_ded_err  out  1  double-bit error detected on this read; data uncorrectable.
REQ-019 o_sec_cnt, o_ded_cnt  out  CNT_W  saturating error counts.

Function
REQ-020 An accepted write (i_fifo_wreq & write-allowed) shall store encode(i_data) XOR i_inj_mask.
- Encoding is extended Hamming SECDED.
- Check bits sit at positions 2^k (1-based); bit 0 is overall parity.
REQ-021 Writes shall be allowed when not full, or when full with an accepted read in the same cycle.
REQ-022 Reads shall be accepted only when not empty.
- A read when empty is ignored, with no pointer change and o_valid=0.
- There is no fall-through: a write into an empty FIFO with a simultaneous read accepts only the write.
REQ-023 Read latency shall be 1 cycle: o_valid, o_data and the flags are registered and asserted the cycle after read acceptance, for one cycle.
REQ-024 Decode shall compute the syndrome S and overall parity P.
- S=0, P=0: no error.
- P=1: single error. Flip bit S (S=0 means the parity bit). Assert o_sec_err.
- S!=0, P=0: double error. Assert o_ded_err and output the uncorrected data field.
REQ-025 o_sec_err and o_ded_err shall never both be 1, and are 0 whenever o_valid=0.
REQ-026 Counters shall increment on each flagged read and saturate at 2^CNT_W-1.
- i_cnt_clr has priority over an increment in the same cycle.
REQ-027 Read and write pointers shall wrap modulo DEPTH.
- full/empty derive from o_level, which changes by +1, -1 or 0 (simultaneous accepted read and write).
- All status outputs are registered.

Reset
REQ-028 Assertion of reset_n shall asynchronously force:
- pointers and o_level to 0;
- o_fifo_empty=1, o_fifo_full=0;
- o_valid, o_sec_err, o_ded_err to 0;
- o_data to 0;
- counters to 0.
REQ-029 Storage array contents shall not be reset.
- A read pending at reset is discarded.
- After reset deassertion the first accepted read returns the first post-reset write.

Structure
REQ-030 Package secded_pkg shall hold:
- the function computing PW from DW;
- pure encode and syndrome functions parametrised by DW;
- the typedef for decode status (NONE, SEC, DED).
REQ-031 Decoding shall live in sub-module secded_dec:
- combinational;
- input codeword CW bits;
- outputs: data DW bits, status.
- The FIFO registers its outputs.
REQ-032 Storage shall be a flop array of DEPTH x CW; no RAM macro.

Verification
REQ-033 Write 0x155, 0x2AA, 0x3FF with mask 0, then read 3 -> o_data 0x155, 0x2AA, 0x3FF in order, each 1 cycle after rreq, with no flags set.
REQ-034 Write 0x0F0 with mask bit 5 set, then read -> o_data=0x0F0, o_sec_err=1, o_sec_cnt=1.
REQ-035 Write 0x0F0 with mask bits 3 and 9 set, then read -> o_ded_err=1, o_sec_err=0, o_ded_cnt=1.
REQ-036 Fill 8 entries -> o_fifo_full=1, o_level=8; an extra write alone is ignored; simultaneous write+read keeps level 8 and the data order is preserved.
REQ-037 Read when empty -> o_valid stays 0; simultaneous write+read on empty -> level 1, no o_valid.
REQ-038 Force 300 single-bit errors with CNT_W=8 -> o_sec_cnt=255; i_cnt_clr -> 0; asserting reset mid-stream with level 3 -> level 0, empty=1 immediately.

Source files
------------

// File: rtl/secded_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | secded_pkg: extended-Hamming SECDED helpers shared by encoder and decoder   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package secded_pkg;

  localparam int MAX_DW = 64;
  localparam int MAX_PW = 7;
  localparam int MAX_CW = MAX_DW + MAX_PW + 1;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SEC  = 2'd1,
    DED  = 2'd2
  } dec_status_e;

  typedef struct packed {
    logic [MAX_PW-1:0] s;
    logic              p;
  } syndrome_t;

  function automatic int calc_pw(input int dw);
    int pw;
    pw = 0;
    for (int p = MAX_PW; p >= 1; p--) begin
      if ((1 << p) >= dw + p + 1) pw = p;
    end
    return pw;
  endfunction

  function automatic logic is_pow2(input int i);
    return (i & (i - 1)) == 0;
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order.
  function automatic logic [MAX_CW-1:0] secded_encode(input int dw, input logic [MAX_DW-1:0] data);
    logic [MAX_CW-1:0] c;
    logic              par;
    int                cw;
    int                j;
    int                pos;
    c  = '0;
    cw = dw + calc_pw(dw) + 1;
    j  = 0;
    for (int i = 1; i < MAX_CW; i++) begin
      if (i < cw && !is_pow2(i)) begin
        c[i[6:0]] = data[j[5:0]];
        j++;
      end
    end
    for (int k = 0; k < MAX_PW; k++) begin
      par = 1'b0;
      for (int i = 1; i < MAX_CW; i++) begin
        if (((i >> k) & 1) != 0) par = par ^ c[i[6:0]];
      end
      pos = 1 << k;
      if (pos < cw) c[pos[6:0]] = par;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic syndrome_t secded_syndrome(input int dw, input logic [MAX_CW-1:0] c);
    syndrome_t r;
    int        cw;
    cw  = dw + calc_pw(dw) + 1;
    r.s = '0;
    r.p = c[0];
    for (int i = 1; i < MAX_CW; i++) begin
      if (i < cw && c[i[6:0]]) begin
        r.s = r.s ^ i[MAX_PW-1:0];
        r.p = ~r.p;
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_DW-1:0] secded_extract(input int dw, input logic [MAX_CW-1:0] c);
    logic [MAX_DW-1:0] d;
    int                cw;
    int                j;
    d  = '0;
    cw = dw + calc_pw(dw) + 1;
    j  = 0;
    for (int i = 1; i < MAX_CW; i++) begin
      if (i < cw && !is_pow2(i)) begin
        d[j[5:0]] = c[i[6:0]];
        j++;
      end
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/secded_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | secded_dec: combinational SECDED decoder (correct single, flag double)     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module secded_dec
  import secded_pkg::*;
#(
  parameter int DW = 10,
  parameter int CW = DW + calc_pw(DW) + 1
) (
  input  logic [CW-1:0] cw_i,
  output logic [DW-1:0] data_o,
  output dec_status_e   status_o
);

  logic [MAX_CW-1:0] w_cw;
  logic [MAX_CW-1:0] w_fixed;
  logic [MAX_DW-1:0] w_data;
  syndrome_t         w_syn;
  logic              w_unused;

  always_comb begin
    w_cw          = '0;
    w_cw[CW-1:0]  = cw_i;
    w_syn         = secded_syndrome(DW, w_cw);
    w_fixed       = w_cw;
    status_o      = NONE;
    if (w_syn.p) begin
      status_o = SEC;
      // A syndrome beyond the codeword means a multi-bit hit aliasing as single; nothing to flip.
      if (int'(w_syn.s) < CW) w_fixed[w_syn.s] = ~w_fixed[w_syn.s];
    end else if (w_syn.s != '0) begin
      status_o = DED;
    end
    w_data = secded_extract(DW, w_fixed);
  end

  assign data_o   = w_data[DW-1:0];
  assign w_unused = ^w_data;

endmodule
`default_nettype wire

// File: rtl/secded_ecc_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | secded_ecc_fifo: flop-array FIFO storing SECDED codewords, with counters   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module secded_ecc_fifo
  import secded_pkg::*;
#(
  parameter  int DW    = 10,
  parameter  int DEPTH = 8,
  parameter  int CNT_W = 8,
  localparam int PW    = calc_pw(DW),
  localparam int CW    = DW + PW + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_fifo_wreq,
  input  logic             i_fifo_rreq,
  input  logic [DW-1:0]    i_data,
  input  logic [CW-1:0]    i_inj_mask,
  input  logic             i_cnt_clr,
  output logic             o_fifo_empty,
  output logic             o_fifo_full,
  output logic [AW:0]      o_level,
  output logic [DW-1:0]    o_data,
  output logic             o_valid,
  output logic             o_sec_err,
  output logic             o_ded_err,
  output logic [CNT_W-1:0] o_sec_cnt,
  output logic [CNT_W-1:0] o_ded_cnt
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [CW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       level_q, level_d;
  logic              empty_q, full_q, valid_q, sec_q, ded_q;
  logic [DW-1:0]     data_q;
  logic [CNT_W-1:0]  sec_cnt_q, ded_cnt_q;
  logic              w_rd, w_wr;
  logic [MAX_DW-1:0] w_din;
  logic [MAX_CW-1:0] w_enc;
  logic [DW-1:0]     w_dec_data;
  dec_status_e       w_dec_st;
  logic              w_unused;

  assign w_rd = i_fifo_rreq & ~empty_q;
  assign w_wr = i_fifo_wreq & (~full_q | w_rd);

  always_comb begin
    w_din         = '0;
    w_din[DW-1:0] = i_data;
    w_enc         = secded_encode(DW, w_din);
  end
  assign w_unused = ^w_enc;

  always_comb begin
    level_d = level_q;
    if (w_wr && !w_rd)      level_d = level_q + 1'b1;
    else if (!w_wr && w_rd) level_d = level_q - 1'b1;
  end

  secded_dec #(.DW(DW), .CW(CW)) u_dec (
    .cw_i     (mem_q[rptr_q]),
    .data_o   (w_dec_data),
    .status_o (w_dec_st)
  );

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wptr_q] <= w_enc[CW-1:0] ^ i_inj_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      valid_q   <= 1'b0;
      sec_q     <= 1'b0;
      ded_q     <= 1'b0;
      data_q    <= '0;
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      if (w_wr) wptr_q <= wptr_q + 1'b1;
      if (w_rd) rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == FULL_LVL);
      valid_q <= w_rd;
      sec_q   <= w_rd && (w_dec_st == SEC);
      ded_q   <= w_rd && (w_dec_st == DED);
      if (w_rd) data_q <= w_dec_data;
      if (i_cnt_clr) begin
        sec_cnt_q <= '0;
        ded_cnt_q <= '0;
      end else begin
        if (w_rd && w_dec_st == SEC && sec_cnt_q != '1) sec_cnt_q <= sec_cnt_q + 1'b1;
        if (w_rd && w_dec_st == DED && ded_cnt_q != '1) ded_cnt_q <= ded_cnt_q + 1'b1;
      end
    end
  end

  assign o_fifo_empty = empty_q;
  assign o_fifo_full  = full_q;
  assign o_level      = level_q;
  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_sec_err    = sec_q;
  assign o_ded_err    = ded_q;
  assign o_sec_cnt    = sec_cnt_q;
  assign o_ded_cnt    = ded_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_secded_ecc_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_secded_ecc_fifo: randomized + directed bench with queue reference model |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_secded_ecc_fifo;

  localparam int DW    = 10;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int CW    = 15;
  localparam int CMAX  = 255;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             i_fifo_wreq, i_fifo_rreq, i_cnt_clr;
  logic [DW-1:0]    i_data;
  logic [CW-1:0]    i_inj_mask;
  logic             o_fifo_empty, o_fifo_full, o_valid, o_sec_err, o_ded_err;
  logic [3:0]       o_level;
  logic [DW-1:0]    o_data;
  logic [CNT_W-1:0] o_sec_cnt, o_ded_cnt;

  always #5 clk = ~clk;

  secded_ecc_fifo #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_fifo_wreq  (i_fifo_wreq),
    .i_fifo_rreq  (i_fifo_rreq),
    .i_data       (i_data),
    .i_inj_mask   (i_inj_mask),
    .i_cnt_clr    (i_cnt_clr),
    .o_fifo_empty (o_fifo_empty),
    .o_fifo_full  (o_fifo_full),
    .o_level      (o_level),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_sec_err    (o_sec_err),
    .o_ded_err    (o_ded_err),
    .o_sec_cnt    (o_sec_cnt),
    .o_ded_cnt    (o_ded_cnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] m;
  } ent_t;

  ent_t          mq[$];
  bit            m_valid, m_sec, m_ded;
  logic [DW-1:0] m_data;
  int            m_scnt, m_dcnt;
  bit            chk_en;
  int            total, bad;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Data field as seen in a codeword: data bit j lives at the j-th non-power-of-two position.
  function automatic logic [DW-1:0] field_of(input logic [CW-1:0] m);
    logic [DW-1:0] r;
    int            j;
    r = '0;
    j = 0;
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        r[j] = m[p];
        j++;
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] rmask(input int wt);
    logic [CW-1:0] m;
    int            p1, p2;
    m  = '0;
    p1 = $urandom_range(0, CW - 1);
    if (wt >= 1) m[p1] = 1'b1;
    if (wt == 2) begin
      do p2 = $urandom_range(0, CW - 1); while (p2 == p1);
      m[p2] = 1'b1;
    end
    return m;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_valid = 0; m_sec = 0; m_ded = 0;
    m_scnt  = 0; m_dcnt = 0;
  endfunction

  function automatic void model_edge(input bit w, input bit r, input logic [DW-1:0] d,
                                     input logic [CW-1:0] m, input bit c);
    bit   rd, wr;
    int   wt;
    ent_t e;
    rd = r && (mq.size() > 0);
    wr = w && ((mq.size() < DEPTH) || rd);
    if (rd) begin
      e       = mq.pop_front();
      wt      = $countones(e.m);
      m_valid = 1;
      m_sec   = (wt == 1);
      m_ded   = (wt == 2);
      m_data  = (wt == 2) ? (e.d ^ field_of(e.m)) : e.d;
    end else begin
      m_valid = 0; m_sec = 0; m_ded = 0;
    end
    if (c) begin
      m_scnt = 0; m_dcnt = 0;
    end else begin
      if (m_sec && m_scnt < CMAX) m_scnt++;
      if (m_ded && m_dcnt < CMAX) m_dcnt++;
    end
    if (wr) mq.push_back('{d, m});
  endfunction

  task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d,
                       input logic [CW-1:0] m, input bit c);
    i_fifo_wreq = w;
    i_fifo_rreq = r;
    i_data      = d;
    i_inj_mask  = m;
    i_cnt_clr   = c;
    @(posedge clk);
    model_edge(w, r, d, m, c);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 64'(o_level), 64'(mq.size()));
      chk("empty", 64'(o_fifo_empty), 64'(mq.size() == 0));
      chk("full", 64'(o_fifo_full), 64'(mq.size() == DEPTH));
      chk("valid", 64'(o_valid), 64'(m_valid));
      chk("sec_err", 64'(o_sec_err), 64'(m_sec));
      chk("ded_err", 64'(o_ded_err), 64'(m_ded));
      if (m_valid) chk("data", 64'(o_data), 64'(m_data));
      chk("sec_cnt", 64'(o_sec_cnt), 64'(m_scnt));
      chk("ded_cnt", 64'(o_ded_cnt), 64'(m_dcnt));
    end
  end

  logic [DW-1:0] lit [3];
  logic [DW-1:0] wd  [DEPTH];

  initial begin
    total = 0; bad = 0; chk_en = 0;
    reset_n = 1'b0;
    i_fifo_wreq = 0; i_fifo_rreq = 0; i_cnt_clr = 0; i_data = '0; i_inj_mask = '0;
    model_reset();
    #8;
    chk("rst_empty", 64'(o_fifo_empty), 64'd1);
    chk("rst_full", 64'(o_fifo_full), 64'd0);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_cnt", 64'({o_sec_cnt, o_ded_cnt}), 64'd0);
    #4 reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;

    // In-order clean reads, one cycle after each read request
    lit[0] = 10'h155; lit[1] = 10'h2AA; lit[2] = 10'h3FF;
    for (int i = 0; i < 3; i++) cycle(1, 0, lit[i], '0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, '0, '0, 0);
      chk("clean_valid", 64'(o_valid), 64'd1);
      chk("clean_data", 64'(o_data), 64'(lit[i]));
      chk("clean_flags", 64'({o_sec_err, o_ded_err}), 64'd0);
    end

    // Single-bit injection at codeword bit 5
    cycle(1, 0, 10'h0F0, 15'h0020, 0);
    cycle(0, 1, '0, '0, 0);
    chk("sec_data", 64'(o_data), 64'h0F0);
    chk("sec_flag", 64'(o_sec_err), 64'd1);
    chk("sec_cnt1", 64'(o_sec_cnt), 64'd1);

    // Double-bit injection at codeword bits 3 and 9
    cycle(1, 0, 10'h0F0, 15'h0208, 0);
    cycle(0, 1, '0, '0, 0);
    chk("ded_flag", 64'(o_ded_err), 64'd1);
    chk("ded_nosec", 64'(o_sec_err), 64'd0);
    chk("ded_cnt1", 64'(o_ded_cnt), 64'd1);
    chk("ded_rawdata", 64'(o_data), 64'h0E1);

    // Fill to full, blocked write, then write+read while full
    for (int i = 0; i < DEPTH; i++) begin
      wd[i] = 10'((i * 41 + 7) & 10'h3FF);
      cycle(1, 0, wd[i], '0, 0);
    end
    chk("full_flag", 64'(o_fifo_full), 64'd1);
    chk("full_level", 64'(o_level), 64'd8);
    cycle(1, 0, 10'h3C3, '0, 0);
    chk("full_block", 64'(o_level), 64'd8);
    cycle(1, 1, 10'h111, '0, 0);
    chk("full_rw_level", 64'(o_level), 64'd8);
    chk("full_rw_data", 64'(o_data), 64'(wd[0]));
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, '0, '0, 0);
    chk("full_last", 64'(o_data), 64'h111);

    // Empty-side behaviour: no read, no fall-through
    cycle(0, 1, '0, '0, 0);
    chk("empty_rd_valid", 64'(o_valid), 64'd0);
    cycle(1, 1, 10'h2B4, '0, 0);
    chk("empty_rw_level", 64'(o_level), 64'd1);
    chk("empty_rw_valid", 64'(o_valid), 64'd0);
    cycle(0, 1, '0, '0, 0);
    chk("empty_rw_data", 64'(o_data), 64'h2B4);

    // Randomized traffic with 0/1/2-bit injections
    for (int n = 0; n < 1500; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom),
            rmask($urandom_range(0, 2)), ($urandom_range(0, 49) == 0));
    end
    while (mq.size() > 0) cycle(0, 1, '0, '0, 0);

    // Counter saturation and clear
    cycle(0, 0, '0, '0, 1);
    for (int n = 0; n < 300; n++) begin
      cycle(1, 0, 10'($urandom), rmask(1), 0);
      cycle(0, 1, '0, '0, 0);
    end
    chk("sat_sec_cnt", 64'(o_sec_cnt), 64'd255);
    cycle(0, 0, '0, '0, 1);
    chk("clr_sec_cnt", 64'(o_sec_cnt), 64'd0);
    chk("clr_ded_cnt", 64'(o_ded_cnt), 64'd0);

    // Asynchronous reset with three entries stored and a read just completed
    for (int i = 0; i < 4; i++) cycle(1, 0, 10'(i + 16), '0, 0);
    cycle(0, 1, '0, '0, 0);
    chk("pre_rst_level", 64'(o_level), 64'd3);
    chk_en = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_level", 64'(o_level), 64'd0);
    chk("async_empty", 64'(o_fifo_empty), 64'd1);
    chk("async_valid", 64'(o_valid), 64'd0);
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;
    cycle(1, 0, 10'h19A, '0, 0);
    cycle(0, 1, '0, '0, 0);
    chk("post_rst_data", 64'(o_data), 64'h19A);
    chk("post_rst_level", 64'(o_level), 64'd0);
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
